// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS main controller:
// state encoding, opcode/funct values, ALU codes and datapath mux selects.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      IWB     = 4'd10,
      JEX     = 4'd11,
      BNEEX   = 4'd12,
      LOGIEX  = 4'd13
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Internal ALU operation class handed to the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_LOGI  = 2'b11;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States that hold a memory access open until mem_ready
   function automatic logic is_mem_wait(state_t s);
      return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
   endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath bundle: IR fields, ALU flag and memory ready in,
// mux selects, enables and debug state out.
//   master : the controller (drives controls, samples op/funct/zero/mem_ready)
//   slave  : the datapath/memory side
interface mc_control_fsm_if;
   import mc_ctrl_pkg::*;

   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;

   logic       pcen;
   logic       mem_req;
   logic       memwrite;
   logic       irwrite;
   logic       regwrite;
   logic       iord;
   logic       memtoreg;
   logic       regdst;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [2:0] alucontrol;
   logic       zeroext;
   logic       illegal_op;
   logic       mem_timeout;
   logic [3:0] state;

   modport master (
      input  op, funct, zero, mem_ready,
      output pcen, mem_req, memwrite, irwrite, regwrite, iord, memtoreg,
             regdst, alusrca, alusrcb, pcsrc, alucontrol, zeroext,
             illegal_op, mem_timeout, state
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  pcen, mem_req, memwrite, irwrite, regwrite, iord, memtoreg,
             regdst, alusrca, alusrcb, pcsrc, alucontrol, zeroext,
             illegal_op, mem_timeout, state
   );

endinterface

// File: rtl/mc_alu_dec.sv
// ALU decoder: maps the controller's ALU operation class plus op/funct
// to the 3-bit ALU control code.
//   aluop        in  2  00 add, 01 sub, 10 from funct, 11 logic-immediate
//   op           in  6  opcode (selects and/or for logic-immediate)
//   funct        in  6  R-type function field
//   alucontrol_c out 3  ALU operation (combinational)
module mc_alu_dec
   import mc_ctrl_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol_c
);

   always_comb begin
      alucontrol_c = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol_c = ALU_ADD;
         ALUOP_SUB: alucontrol_c = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alucontrol_c = ALU_ADD;
               FN_SUB:  alucontrol_c = ALU_SUB;
               FN_AND:  alucontrol_c = ALU_AND;
               FN_OR:   alucontrol_c = ALU_OR;
               FN_SLT:  alucontrol_c = ALU_SLT;
               default: alucontrol_c = ALU_ADD;
            endcase
         end
         ALUOP_LOGI: alucontrol_c = (op == OP_ORI) ? ALU_OR : ALU_AND;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller. Sequences the shared datapath through
// fetch/decode/execute/memory/writeback, stalling memory states on
// mem_ready with an optional wait timeout.
//   clk    in  system clock, rising edge
//   reset  in  synchronous, active-high
//   bus    master side of mc_control_fsm_if (IR fields, zero, mem_ready in;
//          datapath controls, illegal_op, mem_timeout, debug state out)
// Controls are decoded from the state register; the pcen branch term and
// the FETCH strobes also depend on zero/mem_ready in the same cycle.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 0,
   parameter int unsigned TO_W           = 8
) (
   input  logic             clk,
   input  logic             reset,
   mc_control_fsm_if.master bus
);

   localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
   // Counter value seen on the last permitted wait cycle
   localparam logic [TO_W-1:0] TO_LAST =
      TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   state_t          state_q, state_n;
   logic [TO_W-1:0] to_cnt_q, to_cnt_n;
   logic            waiting;
   logic            expire;
   logic [1:0]      aluop;
   logic            alu_en;
   logic [2:0]      alu_dec_c;

   // State and wait-counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= FETCH;
         to_cnt_q <= '0;
      end else begin
         state_q  <= state_n;
         to_cnt_q <= to_cnt_n;
      end
   end

   // Wait timeout: counts stalled cycles, clears whenever the state moves on
   always_comb begin
      waiting  = is_mem_wait(state_q) && !bus.mem_ready;
      expire   = TO_EN && waiting && (to_cnt_q == TO_LAST);
      to_cnt_n = (waiting && !expire) ? to_cnt_q + TO_W'(1) : '0;
   end

   // Next state and control decode
   always_comb begin
      state_n         = state_q;
      aluop           = ALUOP_ADD;
      alu_en          = 1'b0;
      bus.pcen        = 1'b0;
      bus.mem_req     = 1'b0;
      bus.memwrite    = 1'b0;
      bus.irwrite     = 1'b0;
      bus.regwrite    = 1'b0;
      bus.iord        = 1'b0;
      bus.memtoreg    = 1'b0;
      bus.regdst      = 1'b0;
      bus.alusrca     = 1'b0;
      bus.alusrcb     = SRCB_B;
      bus.pcsrc       = PCSRC_ALU;
      bus.zeroext     = 1'b0;
      bus.illegal_op  = 1'b0;
      bus.mem_timeout = 1'b0;

      case (state_q)
         FETCH: begin
            bus.mem_req = 1'b1;
            bus.alusrcb = SRCB_FOUR;
            alu_en      = 1'b1;
            bus.irwrite = bus.mem_ready;
            bus.pcen    = bus.mem_ready;
            if (bus.mem_ready) state_n = DECODE;
         end
         DECODE: begin
            bus.alusrcb = SRCB_IMMSH;
            alu_en      = 1'b1;
            case (bus.op)
               OP_LW, OP_SW:     state_n = MEMADR;
               OP_RTYPE:         state_n = RTYPEEX;
               OP_BEQ:           state_n = BEQEX;
               OP_BNE:           state_n = BNEEX;
               OP_ADDI:          state_n = ADDIEX;
               OP_ANDI, OP_ORI:  state_n = LOGIEX;
               OP_J:             state_n = JEX;
               default: begin
                  bus.illegal_op = 1'b1;
                  state_n        = FETCH;
               end
            endcase
         end
         MEMADR: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = SRCB_IMM;
            alu_en      = 1'b1;
            state_n     = (bus.op == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            bus.mem_req = 1'b1;
            bus.iord    = 1'b1;
            if (bus.mem_ready) state_n = MEMWB;
         end
         MEMWB: begin
            bus.regwrite = 1'b1;
            bus.memtoreg = 1'b1;
            state_n      = FETCH;
         end
         MEMWR: begin
            bus.mem_req  = 1'b1;
            bus.iord     = 1'b1;
            bus.memwrite = 1'b1;
            if (bus.mem_ready) state_n = FETCH;
         end
         RTYPEEX: begin
            bus.alusrca = 1'b1;
            aluop       = ALUOP_FUNCT;
            alu_en      = 1'b1;
            state_n     = RTYPEWB;
         end
         RTYPEWB: begin
            bus.regwrite = 1'b1;
            bus.regdst   = 1'b1;
            state_n      = FETCH;
         end
         BEQEX, BNEEX: begin
            bus.alusrca = 1'b1;
            aluop       = ALUOP_SUB;
            alu_en      = 1'b1;
            bus.pcsrc   = PCSRC_ALUOUT;
            bus.pcen    = (state_q == BEQEX) ? bus.zero : !bus.zero;
            state_n     = FETCH;
         end
         ADDIEX: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = SRCB_IMM;
            alu_en      = 1'b1;
            state_n     = IWB;
         end
         LOGIEX: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = SRCB_IMM;
            bus.zeroext = 1'b1;
            aluop       = ALUOP_LOGI;
            alu_en      = 1'b1;
            state_n     = IWB;
         end
         IWB: begin
            bus.regwrite = 1'b1;
            state_n      = FETCH;
         end
         JEX: begin
            bus.pcsrc = PCSRC_JUMP;
            bus.pcen  = 1'b1;
            state_n   = FETCH;
         end
         default: state_n = FETCH;
      endcase

      // Abandon the stalled access; mem_ready on the same cycle never expires
      if (expire) begin
         bus.mem_timeout = 1'b1;
         bus.memwrite    = 1'b0;
         bus.irwrite     = 1'b0;
         bus.pcen        = 1'b0;
         state_n         = FETCH;
      end

      // Side-effecting strobes are suppressed while reset is sampled high
      if (reset) begin
         bus.pcen        = 1'b0;
         bus.irwrite     = 1'b0;
         bus.regwrite    = 1'b0;
         bus.memwrite    = 1'b0;
         bus.mem_req     = 1'b0;
         bus.illegal_op  = 1'b0;
         bus.mem_timeout = 1'b0;
      end
   end

   mc_alu_dec u_alu_dec (
      .aluop        (aluop),
      .op           (bus.op),
      .funct        (bus.funct),
      .alucontrol_c (alu_dec_c)
   );

   // ALU control reads 0 in states that do not use the ALU
   assign bus.alucontrol = alu_en ? alu_dec_c : 3'b000;
   assign bus.state      = state_q;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multicycle MIPS main controller. It sequences the shared datapath (PC, IR, register file, ALU, unified instruction/data memory and memory-mapped IO) through fetch, decode, execute, memory and writeback states. It adds a memory request/ready handshake so slow IO targets can stall any memory state. It instantiates inside `top` between the IR opcode/funct fields and the datapath mux/enable controls.

Parameters:
- TIMEOUT_CYCLES, default 0, max cycles a memory state waits for mem_ready; 0 disables the timeout.
- TO_W, default 8, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2^TO_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory/IO completes the current access this cycle.
- pcen  out  1  PC load enable.
- mem_req  out  1  memory access active.
- memwrite  out  1  store strobe.
- irwrite  out  1  IR load.
- regwrite  out  1  register file write.
- iord  out  1  memory address select, 0=PC, 1=ALUOut.
- memtoreg  out  1  writeback select, 1=Data register.
- regdst  out  1  destination select, 1=rd, 0=rt.
- alusrca  out  1  ALU A select, 0=PC, 1=A.
- alusrcb  out  2  ALU B select: 00=B, 01=4, 10=imm, 11=imm<<2.
- pcsrc  out  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target.
- alucontrol  out  3  ALU operation.
- zeroext  out  1  zero-extend the immediate, for andi/ori.
- illegal_op  out  1  unrecognised opcode seen in DECODE.
- mem_timeout  out  1  one-cycle pulse when a memory wait expires.
- state  out  4  current state, for debug.

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high.
- Reset: on a rising edge with reset=1, state becomes FETCH and the timeout counter clears. While reset=1, pcen, irwrite, regwrite, memwrite, mem_req, illegal_op and mem_timeout are forced to 0. All outputs are Moore, decoded from state, except the pcen branch term and the FETCH strobes gated by mem_ready.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, IWB=10, JEX=11, BNEEX=12, LOGIEX=13.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00. irwrite and pcen equal mem_ready. Advance to DECODE only when mem_ready=1.
- DECODE: alusrca=0, alusrcb=11, add. Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 -> BEQEX
  - 000101 -> BNEEX
  - 001000 -> ADDIEX
  - 001100 or 001101 -> LOGIEX
  - 000010 -> JEX
  - anything else -> illegal_op=1 for this cycle, then FETCH.
- MEMADR: alusrca=1, alusrcb=10, add. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Move to MEMWB on mem_ready.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Next FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1, held every waiting cycle. Move to FETCH on mem_ready.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - other -> 010
  Next RTYPEWB.
- RTYPEWB: regwrite=1, regdst=1, memtoreg=0. Next FETCH.
- BEQEX / BNEEX: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01. pcen=zero for BEQEX, pcen=~zero for BNEEX. Next FETCH.
- ADDIEX: alusrca=1, alusrcb=10, alucontrol=010. Next IWB.
- LOGIEX: alusrca=1, alusrcb=10, zeroext=1. alucontrol=000 for andi, 001 for ori. Next IWB.
- IWB: regwrite=1, regdst=0, memtoreg=0. Next FETCH.
- JEX: pcsrc=10, pcen=1. Next FETCH.
- Unlisted outputs are 0 in every state.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0, and clears on any state change.
  - When it reaches TIMEOUT_CYCLES with mem_ready still 0: pulse mem_timeout, force memwrite=0 and irwrite=0 and pcen=0 that cycle, then go to FETCH. FETCH itself re-enters FETCH.
  - mem_ready=1 on the expiry cycle wins: normal completion, no pulse.
- Reset mid-MEMWR: memwrite drops in the same cycle reset is sampled high; no write completes.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state_t enum with the encoding above;
  - opcode and funct localparams;
  - ALU code localparams (ALU_ADD=010, ALU_SUB=110, ALU_AND=000, ALU_OR=001, ALU_SLT=111);
  - alusrcb and pcsrc select localparams.
- One combinational sub-module, mc_alu_dec, maps an internal aluop (00 add, 01 sub, 10 funct, 11 logic-immediate), op and funct to alucontrol.

Test Plan:
- Reset held 3 cycles, then op=100011, mem_ready=1 -> state sequence 0,1,2,3,4,0. regwrite=1 only in state 4, with memtoreg=1.
- op=101011, mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then state 0. Memory monitor sees exactly one completed write, to address 128.
- op=000100 with zero=1 -> pcen=1, pcsrc=01 in BEQEX. Same with op=000101 -> pcen=0.
- op=000000, funct=101010 -> alucontrol=111 in RTYPEEX. Then regwrite=1, regdst=1.
- op=001101 -> zeroext=1 and alucontrol=001 in LOGIEX, then IWB. op=111111 -> illegal_op pulses once in DECODE, next state 0, no writes.
- TIMEOUT_CYCLES=4, mem_ready=0 in MEMRD -> mem_timeout pulses on the 4th wait cycle, then FETCH. Reset asserted in MEMWR -> memwrite=0 that cycle, state=0 the next.
